// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
// Reads one configuration word per user-project pad from the housekeeping
// register file and shifts it, MSB first, into the daisy-chained GPIO control
// blocks. Once the whole chain has been shifted, the block pulses serial_load
// so every control block moves its shift register into its active config.
//
// Ports:
//   clock_core     core clock
//   rstb           asynchronous active-low reset
//   xfer_start     single-cycle request to start a full chain transfer
//   xfer_busy      high while a transfer is in progress
//   xfer_done      one-cycle pulse when the transfer completes
//   cfg_addr       pad index presented to the register file
//   cfg_data       configuration word for cfg_addr (combinational read)
//   serial_clock   shift clock to the chain
//   serial_data    shift data to the chain
//   serial_load    latch strobe to the chain
//   serial_resetn  active-low chain reset
module gpio_serial_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int ADDR_W   = 6,
    parameter int CLK_DIV  = 1
) (
    input  logic                clock_core,
    input  logic                rstb,
    input  logic                xfer_start,
    output logic                xfer_busy,
    output logic                xfer_done,
    output logic [ADDR_W-1:0]   cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_data,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load,
    output logic                serial_resetn
);

    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t              state;
    logic [CFG_BITS-1:0] shift_reg;
    logic [CFG_BITS-1:0] shift_next;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          rsn_sync;
    logic                div_end;
    logic                last_bit;
    logic                last_pad;

    // Chain reset asserts with rstb and releases two core edges later.
    always_ff @(posedge clock_core or negedge rstb) begin
        if (!rstb) begin
            rsn_sync <= '0;
        end else begin
            rsn_sync <= {rsn_sync[0], 1'b1};
        end
    end

    assign serial_resetn = rsn_sync[1];

    assign shift_next = shift_reg << 1;
    assign div_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_bit   = (bit_cnt == BIT_W'(CFG_BITS - 1));
    // cfg_addr doubles as the pad index.
    assign last_pad   = (cfg_addr == ADDR_W'(NUM_PADS - 1));

    // Outputs are assigned on the edge that enters the state they belong to,
    // so each one is a plain flop and changes only with the state.
    always_ff @(posedge clock_core or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            cfg_addr     <= '0;
            xfer_busy    <= 1'b0;
            xfer_done    <= 1'b0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_clock <= 1'b0;
                    serial_data  <= 1'b0;
                    serial_load  <= 1'b0;
                    if (xfer_start) begin
                        cfg_addr  <= '0;
                        xfer_busy <= 1'b1;
                        state     <= FETCH;
                    end
                end

                FETCH: begin
                    shift_reg    <= cfg_data;
                    bit_cnt      <= '0;
                    div_cnt      <= '0;
                    serial_clock <= 1'b0;
                    serial_data  <= cfg_data[CFG_BITS-1];
                    state        <= SHIFT_LO;
                end

                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b1;
                        state        <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt      <= '0;
                        serial_clock <= 1'b0;
                        shift_reg    <= shift_next;
                        bit_cnt      <= bit_cnt + BIT_W'(1);
                        if (!last_bit) begin
                            // Next bit goes out with the falling edge.
                            serial_data <= shift_next[CFG_BITS-1];
                            state       <= SHIFT_LO;
                        end else if (!last_pad) begin
                            serial_data <= 1'b0;
                            cfg_addr    <= cfg_addr + ADDR_W'(1);
                            state       <= FETCH;
                        end else begin
                            serial_data <= 1'b0;
                            serial_load <= 1'b1;
                            state       <= LOAD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                LOAD: begin
                    if (div_end) begin
                        div_cnt     <= '0;
                        serial_load <= 1'b0;
                        xfer_busy   <= 1'b0;
                        xfer_done   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    // A start seen here is dropped: the FSM always idles first.
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: three configurations (defaults, a 2x4 chain,
// and a 3x5 chain with CLK_DIV=3) are checked against a behavioural chain
// model and timing derived from the transfer arithmetic.
module tb_gpio_serial_loader;

    logic        clk = 1'b0;
    logic        rstb;
    logic [2:0]  start_v;
    logic [12:0] drive;
    logic [12:0] mem [0:63];

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    int np, cb, cd;

    always #5 clk = ~clk;

    logic       a_busy, a_done, a_sclk, a_sdata, a_load, a_rsn;
    logic       b_busy, b_done, b_sclk, b_sdata, b_load, b_rsn;
    logic       c_busy, c_done, c_sclk, c_sdata, c_load, c_rsn;
    logic [5:0] a_addr, b_addr, c_addr;

    gpio_serial_loader #(.NUM_PADS(38), .CFG_BITS(13), .ADDR_W(6), .CLK_DIV(1)) dut_a (
        .clock_core(clk), .rstb(rstb), .xfer_start(start_v[0]),
        .xfer_busy(a_busy), .xfer_done(a_done), .cfg_addr(a_addr),
        .cfg_data(drive), .serial_clock(a_sclk), .serial_data(a_sdata),
        .serial_load(a_load), .serial_resetn(a_rsn)
    );

    gpio_serial_loader #(.NUM_PADS(2), .CFG_BITS(4), .ADDR_W(6), .CLK_DIV(1)) dut_b (
        .clock_core(clk), .rstb(rstb), .xfer_start(start_v[1]),
        .xfer_busy(b_busy), .xfer_done(b_done), .cfg_addr(b_addr),
        .cfg_data(drive[3:0]), .serial_clock(b_sclk), .serial_data(b_sdata),
        .serial_load(b_load), .serial_resetn(b_rsn)
    );

    gpio_serial_loader #(.NUM_PADS(3), .CFG_BITS(5), .ADDR_W(6), .CLK_DIV(3)) dut_c (
        .clock_core(clk), .rstb(rstb), .xfer_start(start_v[2]),
        .xfer_busy(c_busy), .xfer_done(c_done), .cfg_addr(c_addr),
        .cfg_data(drive[4:0]), .serial_clock(c_sclk), .serial_data(c_sdata),
        .serial_load(c_load), .serial_resetn(c_rsn)
    );

    logic       m_busy, m_done, m_sclk, m_sdata, m_load, m_rsn;
    logic [5:0] m_addr;

    always_comb begin
        m_busy = a_busy; m_done = a_done; m_sclk = a_sclk;
        m_sdata = a_sdata; m_load = a_load; m_rsn = a_rsn; m_addr = a_addr;
        case (sel)
            1: begin
                m_busy = b_busy; m_done = b_done; m_sclk = b_sclk;
                m_sdata = b_sdata; m_load = b_load; m_rsn = b_rsn; m_addr = b_addr;
            end
            2: begin
                m_busy = c_busy; m_done = c_done; m_sclk = c_sclk;
                m_sdata = c_sdata; m_load = c_load; m_rsn = c_rsn; m_addr = c_addr;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic use_dut(input int s);
        sel = s;
        case (s)
            1:       begin np = 2;  cb = 4;  cd = 1; end
            2:       begin np = 3;  cb = 5;  cd = 3; end
            default: begin np = 38; cb = 13; cd = 1; end
        endcase
        #1;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 64; i++) mem[i] = 13'($urandom);
    endtask

    // Register-file behaviour for cycle n of a transfer: the real word is
    // presented only in FETCH cycles, junk everywhere else.
    task automatic drive_cfg(input int n, input int p_len);
        if ((n - 1) % p_len == 0 && (n - 1) / p_len < np) begin
            check("fetch_addr", 32'(m_addr), 32'((n - 1) / p_len));
            drive = mem[m_addr];
        end else begin
            drive = 13'($urandom);
        end
    endtask

    // Caller is just past a rising edge. One full transfer, cycle 1 = FETCH.
    task automatic run_xfer(input bit with_extra);
        int          p_len, lat, rises, hi_len, load_cnt, first_load, pad, bitn;
        logic        prev, rise_data;
        logic [12:0] mask;
        logic [12:0] chain  [0:37];
        logic [12:0] active [0:37];

        p_len = 1 + 2 * cd * cb;
        lat   = np * p_len + cd + 1;
        mask  = 13'((32'd1 << cb) - 1);
        for (int k = 0; k < 38; k++) begin
            chain[k]  = '0;
            active[k] = '0;
        end
        rises = 0; hi_len = 0; load_cnt = 0; first_load = -1;
        prev = 1'b0; rise_data = 1'b0;

        start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v = '0;

        for (int n = 1; n <= lat; n++) begin
            @(negedge clk);
            drive_cfg(n, p_len);
            if (m_sclk && !prev) begin
                if (rises < np * cb) begin
                    pad  = rises / cb;
                    bitn = cb - 1 - (rises % cb);
                    check("rise_data", 32'(m_sdata), 32'(mem[pad][bitn]));
                end
                for (int k = 0; k < np - 1; k++)
                    chain[k] = ((chain[k] << 1) | 13'(chain[k+1][cb-1])) & mask;
                chain[np-1] = ((chain[np-1] << 1) | 13'(m_sdata)) & mask;
                rises++;
                hi_len    = 1;
                rise_data = m_sdata;
            end else if (m_sclk) begin
                hi_len++;
                check("hold_data", 32'(m_sdata), 32'(rise_data));
            end else if (prev) begin
                check("hi_len", 32'(hi_len), 32'(cd));
            end
            check("clk_load_excl", 32'(m_sclk & m_load), 32'd0);
            if (m_load) begin
                if (load_cnt == 0) begin
                    first_load = n;
                    for (int k = 0; k < 38; k++) active[k] = chain[k];
                end
                load_cnt++;
            end
            if (n < lat) begin
                check("busy", 32'(m_busy), 32'd1);
                check("done_early", 32'(m_done), 32'd0);
            end else begin
                check("done", 32'(m_done), 32'd1);
                check("busy_at_done", 32'(m_busy), 32'd0);
            end
            prev = m_sclk;
            if (with_extra) start_v[sel] = (n == 5 || n == 100 || n == lat);
        end
        @(posedge clk); #1 start_v = '0;

        check("rise_count", 32'(rises), 32'(np * cb));
        check("load_len", 32'(load_cnt), 32'(cd));
        check("load_cycle", 32'(first_load), 32'(lat - cd));
        for (int k = 0; k < np; k++)
            check("pad_latched", 32'(active[k]), 32'(mem[k] & mask));
    endtask

    task automatic idle_check(input int cycles, input int exp_addr);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(m_busy), 32'd0);
            check("idle_done", 32'(m_done), 32'd0);
            check("idle_sclk", 32'(m_sclk | m_load), 32'd0);
            check("idle_addr", 32'(m_addr), 32'(exp_addr));
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {25'd0, m_busy, m_done, m_sclk, m_sdata, m_load, m_rsn, |m_addr}, 32'd0);
    endtask

    // Reset during SHIFT_HI of pad 1, bit 2.
    task automatic abort_xfer();
        int p_len, hit;
        p_len = 1 + 2 * cd * cb;
        hit   = (1 + p_len) + 1 + 4 * cd + cd;
        start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v = '0;
        for (int n = 1; n <= hit; n++) begin
            @(negedge clk);
            drive_cfg(n, p_len);
            check("abort_no_load", 32'(m_load), 32'd0);
        end
        check("abort_phase", 32'(m_sclk), 32'd1);
        rstb = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) begin
            @(negedge clk);
            check_all_zero("held_reset");
        end
        #1 rstb = 1'b1;
        @(posedge clk); #1 check("rsn_edge1", 32'(m_rsn), 32'd0);
        @(posedge clk); #1 check("rsn_edge2", 32'(m_rsn), 32'd1);
        check("no_restart", 32'(m_busy), 32'd0);
    endtask

    initial begin
        rstb    = 1'b0;
        start_v = '0;
        drive   = '0;
        rand_mem();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            use_dut(s);
            check_all_zero("reset_vals");
        end
        @(negedge clk) rstb = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        use_dut(0);
        run_xfer(1'b0);
        idle_check(3, np - 1);
        rand_mem();
        run_xfer(1'b1);
        idle_check(3, np - 1);
        rand_mem();
        run_xfer(1'b0);
        run_xfer(1'b0);
        idle_check(2, np - 1);
        abort_xfer();
        idle_check(2, 0);
        rand_mem();
        run_xfer(1'b0);
        idle_check(2, np - 1);

        use_dut(1);
        mem[0] = 13'h000A;
        mem[1] = 13'h0005;
        run_xfer(1'b0);
        idle_check(2, np - 1);

        use_dut(2);
        rand_mem();
        run_xfer(1'b0);
        idle_check(2, np - 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
